truco_aposta: RTL and testbench
===============================

TRUCO_APOSTA -- requirements
Module: truco_aposta

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all logic updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-low; rst=0 at a rising clk edge resets the block.
REQ-003 SHALL have port pede_a, input, 1 bit: debounced one-cycle pulse; team A asks to raise the hand value.
REQ-004 SHALL have port pede_b, input, 1 bit: debounced one-cycle pulse; team B asks to raise the hand value.
REQ-005 SHALL have port aceita, input, 1 bit: one-cycle pulse; the responding team accepts the pending raise.
REQ-006 SHALL have port corre, input, 1 bit: one-cycle pulse; the responding team folds on the pending raise.
REQ-007 SHALL have port vence_a, input, 1 bit: one-cycle pulse; team A won the hand.
REQ-008 SHALL have port vence_b, input, 1 bit: one-cycle pulse; team B won the hand.
REQ-009 SHALL have port jogo_encerrado, input, 1 bit: game over; while high, all other inputs are ignored.
REQ-010 SHALL have port valor_mao, output, 4 bits: current accepted hand value, one of 1, 3, 6, 9 or 12.
REQ-011 SHALL have port proposta, output, 4 bits: value under offer while aguardando=1; equals valor_mao otherwise.
REQ-012 SHALL have port aguardando, output, 1 bit: a raise is pending a response.
REQ-013 SHALL have port ultimo_pedido, output, 2 bits: 00 = no raise yet, 01 = team A raised last, 10 = team B raised last.
REQ-014 SHALL have port ponto_valido, output, 1 bit: one-cycle award strobe to the scoreboard.
REQ-015 SHALL have port ponto_dupla, output, 1 bit: award target, 0 = A, 1 = B; valid only when ponto_valido=1.
REQ-016 SHALL have port ponto_qtd, output, 4 bits: points awarded; valid only when ponto_valido=1.

Function
REQ-017 SHALL implement three states: JOGANDO (hand in play), ESPERA (raise pending) and PONTUA (award issued).
REQ-018 SHALL use the value ladder 1 -> 3 -> 6 -> 9 -> 12; the next value is computed combinationally from valor_mao.
REQ-019 In JOGANDO, a pede_x pulse SHALL be accepted only if valor_mao < 12 and team x is not the last raiser. On acceptance: proposta <= next ladder value, requester latched, aguardando <= 1, state -> ESPERA next cycle.
REQ-020 In ESPERA, aceita (with corre=0) SHALL set valor_mao <= proposta, ultimo_pedido <= requester, aguardando <= 0, state -> JOGANDO.
REQ-021 In ESPERA, corre (with aceita=0) SHALL award the requester the pre-raise valor_mao and move to PONTUA.
REQ-022 In JOGANDO, vence_x SHALL award team x valor_mao and move to PONTUA.
REQ-023 In PONTUA, for exactly one cycle, the block SHALL drive ponto_valido=1 with ponto_dupla and ponto_qtd registered. The next state is JOGANDO with valor_mao=1, proposta=1, ultimo_pedido=00 and aguardando=0.
REQ-024 Award latency SHALL be exactly one cycle: ponto_valido is high in the cycle after the cycle in which the vence or corre pulse was sampled.
REQ-025 In JOGANDO, if vence_x and pede_y are sampled together, vence SHALL take priority and the raise SHALL be dropped.
REQ-026 In JOGANDO, if vence_a and vence_b are sampled together, both SHALL be ignored; likewise if pede_a and pede_b are sampled together.
REQ-027 In ESPERA, if aceita and corre are sampled together, both SHALL be ignored; vence_a, vence_b, pede_a and pede_b SHALL also be ignored in ESPERA.
REQ-028 In JOGANDO, aceita and corre SHALL be ignored; in PONTUA, all inputs SHALL be ignored.
REQ-029 While jogo_encerrado=1, state and registers SHALL hold and ponto_valido SHALL be 0. An award already in PONTUA still completes its single pulse.
REQ-030 ponto_qtd SHALL never exceed 12, and valor_mao SHALL never hold a value outside the ladder.

Reset
REQ-031 With rst=0, the next edge SHALL produce: state=JOGANDO, valor_mao=1, proposta=1, aguardando=0, ultimo_pedido=00, ponto_valido=0, ponto_dupla=0, ponto_qtd=0.
REQ-032 Reset SHALL override all inputs and SHALL cancel any pending raise or award in progress, including an award in PONTUA, which is lost.

Verification
REQ-033 Sequence: vence_a with no raise -> the next cycle shows ponto_valido=1, ponto_dupla=0, ponto_qtd=1; the cycle after shows valor_mao=1.
REQ-034 Sequence: pede_a, aceita, pede_b, aceita, then vence_b -> valor_mao goes 3 then 6; the award is dupla=1, qtd=6.
REQ-035 Sequence: pede_a, aceita, then pede_a again -> the second pede_a is ignored (aguardando stays 0). Then pede_b followed by corre -> award dupla=1, qtd=3.
REQ-036 Raise alternately up to 12, then pede_x -> ignored; vence_a -> award qtd=12.
REQ-037 In JOGANDO, vence_a and vence_b sampled together -> no award. In ESPERA, aceita and corre sampled together -> still in ESPERA with proposta unchanged.
REQ-038 rst=0 asserted in ESPERA with proposta=6 -> the next cycle shows aguardando=0, valor_mao=1, no ponto_valido. With jogo_encerrado=1, vence_a -> no award.

Source files
------------

// File: rtl/truco_aposta.sv
// Truco hand-value bidding controller: tracks raises (truco/seis/nove/doze),
// responses, and issues a one-cycle point award to the scoreboard.
module truco_aposta (
  input  logic       clk,
  input  logic       rst,
  input  logic       pede_a,
  input  logic       pede_b,
  input  logic       aceita,
  input  logic       corre,
  input  logic       vence_a,
  input  logic       vence_b,
  input  logic       jogo_encerrado,
  output logic [3:0] valor_mao,
  output logic [3:0] proposta,
  output logic       aguardando,
  output logic [1:0] ultimo_pedido,
  output logic       ponto_valido,
  output logic       ponto_dupla,
  output logic [3:0] ponto_qtd
);

  typedef enum logic [1:0] {
    JOGANDO = 2'd0,
    ESPERA  = 2'd1,
    PONTUA  = 2'd2
  } state_t;

  state_t     state, nxt_state;
  logic       req_b;          // 1 = team B made the pending raise
  logic [3:0] prox_valor;
  logic       do_raise, do_accept, do_fold, do_win;

  always_comb begin
    unique case (valor_mao)
      4'd1:    prox_valor = 4'd3;
      4'd3:    prox_valor = 4'd6;
      4'd6:    prox_valor = 4'd9;
      default: prox_valor = 4'd12;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst) state <= JOGANDO;
    else      state <= nxt_state;
  end

  // Next-state logic and event decode
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    nxt_state = state;
    do_raise  = 1'b0;
    do_accept = 1'b0;
    do_fold   = 1'b0;
    do_win    = 1'b0;
    unique case (state)
      JOGANDO: if (!jogo_encerrado) begin
        // A single winner wins; any win pulse suppresses a simultaneous raise.
        if (vence_a ^ vence_b) begin
          do_win    = 1'b1;
          nxt_state = PONTUA;
        end else if (!vence_a && !vence_b && valor_mao != 4'd12 &&
                     ((pede_a && !pede_b && ultimo_pedido != 2'b01) ||
                      (pede_b && !pede_a && ultimo_pedido != 2'b10))) begin
          do_raise  = 1'b1;
          nxt_state = ESPERA;
        end
      end
      ESPERA: if (!jogo_encerrado) begin
        if (aceita && !corre) begin
          do_accept = 1'b1;
          nxt_state = JOGANDO;
        end else if (corre && !aceita) begin
          do_fold   = 1'b1;
          nxt_state = PONTUA;
        end
      end
      PONTUA:  nxt_state = JOGANDO;
      default: nxt_state = JOGANDO;
    endcase
  end

  // Output logic
  always_comb begin
    ponto_valido = (state == PONTUA);
  end

  // Hand value, offer and award registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      valor_mao     <= 4'd1;
      proposta      <= 4'd1;
      aguardando    <= 1'b0;
      ultimo_pedido <= 2'b00;
      req_b         <= 1'b0;
      ponto_dupla   <= 1'b0;
      ponto_qtd     <= 4'd0;
    end else begin
      if (do_raise) begin
        proposta   <= prox_valor;
        req_b      <= pede_b;
        aguardando <= 1'b1;
      end
      if (do_accept) begin
        valor_mao     <= proposta;
        ultimo_pedido <= req_b ? 2'b10 : 2'b01;
        aguardando    <= 1'b0;
      end
      if (do_win) begin
        ponto_dupla <= vence_b;
        ponto_qtd   <= valor_mao;
      end
      // A fold pays the raiser the value that stood before the raise.
      if (do_fold) begin
        ponto_dupla <= req_b;
        ponto_qtd   <= valor_mao;
        proposta    <= valor_mao;
        aguardando  <= 1'b0;
      end
      if (state == PONTUA) begin
        valor_mao     <= 4'd1;
        proposta      <= 4'd1;
        ultimo_pedido <= 2'b00;
        aguardando    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_truco_aposta.sv
// Directed bench for truco_aposta: expected awards go into a queue that a
// monitor drains whenever the DUT raises ponto_valido.
module tb_truco_aposta;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pede_a = 1'b0, pede_b = 1'b0, aceita = 1'b0, corre = 1'b0;
  logic       vence_a = 1'b0, vence_b = 1'b0, jogo_encerrado = 1'b0;
  logic [3:0] valor_mao, proposta, ponto_qtd;
  logic       aguardando, ponto_valido, ponto_dupla;
  logic [1:0] ultimo_pedido;

  int tests  = 0;
  int errors = 0;

  typedef struct packed {
    logic       dupla;
    logic [3:0] qtd;
  } award_t;
  award_t exp_q[$];

  // Input vector bit order: {pede_a, pede_b, aceita, corre, vence_a, vence_b}
  localparam logic [5:0] NADA = 6'b000000;
  localparam logic [5:0] PA   = 6'b100000;
  localparam logic [5:0] PB   = 6'b010000;
  localparam logic [5:0] AC   = 6'b001000;
  localparam logic [5:0] CO   = 6'b000100;
  localparam logic [5:0] VA   = 6'b000010;
  localparam logic [5:0] VB   = 6'b000001;

  truco_aposta dut (
    .clk            (clk),
    .rst            (rst),
    .pede_a         (pede_a),
    .pede_b         (pede_b),
    .aceita         (aceita),
    .corre          (corre),
    .vence_a        (vence_a),
    .vence_b        (vence_b),
    .jogo_encerrado (jogo_encerrado),
    .valor_mao      (valor_mao),
    .proposta       (proposta),
    .aguardando     (aguardando),
    .ultimo_pedido  (ultimo_pedido),
    .ponto_valido   (ponto_valido),
    .ponto_dupla    (ponto_dupla),
    .ponto_qtd      (ponto_qtd)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one input vector for the next rising edge.
  task automatic cyc(input logic [5:0] v);
    @(negedge clk);
    {pede_a, pede_b, aceita, corre, vence_a, vence_b} = v;
  endtask

  task automatic expect_award(input logic dupla, input logic [3:0] qtd);
    award_t a;
    a.dupla = dupla;
    a.qtd   = qtd;
    exp_q.push_back(a);
  endtask

  // Monitor: compares each award strobe against the scoreboard queue.
  initial begin
    award_t a;
    forever begin
      @(negedge clk);
      if (ponto_valido) begin
        if (exp_q.size() == 0) begin
          check("spurious_award", int'(ponto_valido), 0);
        end else begin
          a = exp_q.pop_front();
          check("award_dupla", int'(ponto_dupla), int'(a.dupla));
          check("award_qtd", int'(ponto_qtd), int'(a.qtd));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst = 1'b0;
    cyc(NADA); cyc(NADA);
    check("rst_valor", int'(valor_mao), 1);
    check("rst_proposta", int'(proposta), 1);
    check("rst_aguardando", int'(aguardando), 0);
    check("rst_ultimo", int'(ultimo_pedido), 0);
    check("rst_valido", int'(ponto_valido), 0);
    check("rst_dupla", int'(ponto_dupla), 0);
    check("rst_qtd", int'(ponto_qtd), 0);
    @(negedge clk); rst = 1'b1;

    // Win with no raise pays 1 point to A
    expect_award(1'b0, 4'd1);
    cyc(VA); cyc(NADA);
    check("win1_latency", int'(ponto_valido), 1);
    cyc(NADA);
    check("win1_valor_after", int'(valor_mao), 1);
    check("win1_valido_after", int'(ponto_valido), 0);

    // A raises to 3, accepted; B raises to 6, accepted; B wins 6
    cyc(PA); cyc(NADA);
    check("raise_a_aguard", int'(aguardando), 1);
    check("raise_a_prop", int'(proposta), 3);
    check("raise_a_valor", int'(valor_mao), 1);
    cyc(AC); cyc(NADA);
    check("acc_a_valor", int'(valor_mao), 3);
    check("acc_a_aguard", int'(aguardando), 0);
    check("acc_a_ultimo", int'(ultimo_pedido), 1);
    cyc(PB); cyc(AC); cyc(NADA);
    check("acc_b_valor", int'(valor_mao), 6);
    check("acc_b_ultimo", int'(ultimo_pedido), 2);
    expect_award(1'b1, 4'd6);
    cyc(VB); cyc(NADA); cyc(NADA);
    check("win6_reset_valor", int'(valor_mao), 1);
    check("win6_reset_ultimo", int'(ultimo_pedido), 0);

    // Same team may not raise twice; fold pays pre-raise value
    cyc(PA); cyc(AC); cyc(PA); cyc(NADA);
    check("repeat_raise_ignored", int'(aguardando), 0);
    check("repeat_raise_prop", int'(proposta), 3);
    cyc(PB); cyc(NADA);
    check("raise_b_prop", int'(proposta), 6);
    expect_award(1'b1, 4'd3);
    cyc(CO); cyc(NADA); cyc(NADA);
    check("fold_valor_after", int'(valor_mao), 1);
    check("fold_aguard_after", int'(aguardando), 0);

    // Climb to 12, further raise ignored, win pays 12
    cyc(PA); cyc(AC); cyc(PB); cyc(AC); cyc(PA); cyc(AC); cyc(PB); cyc(AC);
    cyc(NADA);
    check("ladder_top", int'(valor_mao), 12);
    cyc(PA); cyc(NADA);
    check("raise_at_12_ignored", int'(aguardando), 0);
    check("prop_at_12", int'(proposta), 12);
    expect_award(1'b0, 4'd12);
    cyc(VA); cyc(NADA); cyc(NADA);

    // Simultaneous winners ignored
    cyc(VA | VB); cyc(NADA);
    check("double_win_no_award", int'(ponto_valido), 0);
    check("double_win_valor", int'(valor_mao), 1);

    // Simultaneous raises ignored
    cyc(PA | PB); cyc(NADA);
    check("double_raise_ignored", int'(aguardando), 0);

    // Accept and fold together leave the raise pending
    cyc(PA); cyc(AC | CO); cyc(NADA);
    check("acc_co_still_wait", int'(aguardando), 1);
    check("acc_co_prop", int'(proposta), 3);
    check("acc_co_valor", int'(valor_mao), 1);
    cyc(VB); cyc(NADA);
    check("win_in_espera_ignored", int'(ponto_valido), 0);
    cyc(AC); cyc(NADA);
    check("acc_after_conflict", int'(valor_mao), 3);

    // Win beats a simultaneous raise
    expect_award(1'b0, 4'd3);
    cyc(PB | VA); cyc(NADA);
    check("win_beats_raise_aguard", int'(aguardando), 0);
    cyc(NADA);

    // Reset while a raise to 6 is pending
    cyc(PA); cyc(AC); cyc(PB); cyc(NADA);
    check("pre_rst_prop", int'(proposta), 6);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    check("rst_espera_aguard", int'(aguardando), 0);
    check("rst_espera_valor", int'(valor_mao), 1);
    check("rst_espera_valido", int'(ponto_valido), 0);

    // Game over freezes everything
    jogo_encerrado = 1'b1;
    cyc(VA); cyc(NADA);
    check("gameover_no_award", int'(ponto_valido), 0);
    cyc(PA); cyc(NADA);
    check("gameover_no_raise", int'(aguardando), 0);
    @(negedge clk); jogo_encerrado = 1'b0;

    cyc(NADA); cyc(NADA); cyc(NADA);
    check("all_awards_seen", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
